// File: rtl/simd_lane_comparator_if.sv
// Operand/result bus for simd_lane_comparator: valid/ready operand beat in, valid/ready result beat out.
interface simd_lane_comparator_if #(
  parameter int LANES  = 4,
  parameter int LANE_W = 8,
  parameter int CNT_W  = $clog2(LANES + 1)
) ();
  logic                    IN_VALID;
  logic                    IN_READY;
  logic [LANES*LANE_W-1:0] A;
  logic [LANES*LANE_W-1:0] B;
  logic [2:0]              F;
  logic                    SIGNED;
  logic [LANES-1:0]        LANE_EN;
  logic                    OUT_VALID;
  logic                    OUT_READY;
  logic [LANES-1:0]        MASK;
  logic [LANES*LANE_W-1:0] RES;
  logic                    ANY;
  logic                    ALL;
  logic [CNT_W-1:0]        COUNT;

  modport master (
    output IN_VALID, A, B, F, SIGNED, LANE_EN, OUT_READY,
    input  IN_READY, OUT_VALID, MASK, RES, ANY, ALL, COUNT
  );

  modport slave (
    input  IN_VALID, A, B, F, SIGNED, LANE_EN, OUT_READY,
    output IN_READY, OUT_VALID, MASK, RES, ANY, ALL, COUNT
  );
endinterface

// File: rtl/simd_lane_comparator.sv
// Two-stage pipelined SIMD lane comparator: stage 1 registers per-lane eq/lt flags,
// stage 2 applies the {LT,EQ,GT} condition select and produces mask, reductions and SLT-style word.
module simd_lane_comparator #(
  parameter int LANES  = 4,
  parameter int LANE_W = 8,
  parameter int CNT_W  = $clog2(LANES + 1)
) (
  input  logic                    CLK,
  input  logic                    RST,
  simd_lane_comparator_if.slave   bus
);

  logic                    s1_valid;
  logic [LANES-1:0]        s1_eq;
  logic [LANES-1:0]        s1_lt;
  logic [2:0]              s1_f;
  logic [LANES-1:0]        s1_en;

  logic                    s2_valid;
  logic [LANES-1:0]        s2_mask;
  logic                    s2_any;
  logic                    s2_all;
  logic [CNT_W-1:0]        s2_cnt;
  logic [LANES*LANE_W-1:0] s2_res;

  logic                    s2_free;
  logic                    in_ready;
  logic                    accept;

  logic [LANES-1:0]        eq_d;
  logic [LANES-1:0]        lt_d;
  logic [LANES-1:0]        gt_s1;
  logic [LANES-1:0]        mask_d;
  logic                    any_d;
  logic                    all_d;
  logic [CNT_W-1:0]        cnt_d;
  logic [LANES*LANE_W-1:0] res_d;

  // Ready depends only on pipeline occupancy and OUT_READY, never on IN_VALID.
  assign s2_free  = ~s2_valid | bus.OUT_READY;
  assign in_ready = ~s1_valid | s2_free;
  assign accept   = bus.IN_VALID & in_ready;

  always_comb begin
    eq_d = '0;
    lt_d = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      eq_d[i] = (bus.A[i*LANE_W +: LANE_W] == bus.B[i*LANE_W +: LANE_W]);
      if (bus.SIGNED)
        lt_d[i] = ($signed(bus.A[i*LANE_W +: LANE_W]) < $signed(bus.B[i*LANE_W +: LANE_W]));
      else
        lt_d[i] = (bus.A[i*LANE_W +: LANE_W] < bus.B[i*LANE_W +: LANE_W]);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1_valid <= 1'b0;
      s1_eq    <= '0;
      s1_lt    <= '0;
      s1_f     <= '0;
      s1_en    <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_eq    <= eq_d;
      s1_lt    <= lt_d;
      s1_f     <= bus.F;
      s1_en    <= bus.LANE_EN;
    end else if (s2_free) begin
      s1_valid <= 1'b0;
    end
  end

  assign gt_s1 = ~s1_eq & ~s1_lt;

  always_comb begin
    mask_d = s1_en & ((gt_s1 & {LANES{s1_f[0]}}) |
                      (s1_eq & {LANES{s1_f[1]}}) |
                      (s1_lt & {LANES{s1_f[2]}}));
    any_d  = |mask_d;
    all_d  = &(mask_d | ~s1_en);
    cnt_d  = '0;
    res_d  = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      cnt_d = cnt_d + CNT_W'(mask_d[i]);
      res_d[i*LANE_W +: LANE_W] = {{(LANE_W-1){1'b0}}, mask_d[i]};
    end
  end

  // Result registers only reload on a stage-1 transfer, so a stalled beat stays bit-stable.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s2_valid <= 1'b0;
      s2_mask  <= '0;
      s2_any   <= 1'b0;
      s2_all   <= 1'b0;
      s2_cnt   <= '0;
      s2_res   <= '0;
    end else if (s2_free) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_mask <= mask_d;
        s2_any  <= any_d;
        s2_all  <= all_d;
        s2_cnt  <= cnt_d;
        s2_res  <= res_d;
      end
    end
  end

  assign bus.IN_READY  = in_ready;
  assign bus.OUT_VALID = s2_valid;
  assign bus.MASK      = s2_mask;
  assign bus.ANY       = s2_any;
  assign bus.ALL       = s2_all;
  assign bus.COUNT     = s2_cnt;
  assign bus.RES       = s2_res;

endmodule

// File: tb/tb_simd_lane_comparator.sv
// Self-checking bench for simd_lane_comparator (4 lanes x 8 bits): directed table, stall/reset
// sequences, and randomized traffic against a lane-arithmetic reference model with a scoreboard.
module tb_simd_lane_comparator;

  localparam int LANES  = 4;
  localparam int LANE_W = 8;
  localparam int CNT_W  = 3;

  typedef struct packed {
    logic [3:0]  mask;
    logic        any;
    logic        all;
    logic [2:0]  cnt;
    logic [31:0] res;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  f;
    logic        sg;
    logic [3:0]  en;
    exp_t        exp;
  } vec_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  int   n_pop;
  exp_t sbq[$];
  vec_t tbl[10];

  simd_lane_comparator_if #(.LANES(LANES), .LANE_W(LANE_W), .CNT_W(CNT_W)) bus ();

  simd_lane_comparator #(.LANES(LANES), .LANE_W(LANE_W), .CNT_W(CNT_W)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: lanes as plain integers, relation picked from the condition bits.
  function automatic exp_t model(logic [31:0] a, logic [31:0] b, logic [2:0] f,
                                 logic sg, logic [3:0] en);
    exp_t e;
    int   va;
    int   vb;
    int   n;
    logic hit;
    e = '0;
    n = 0;
    for (int i = 0; i < LANES; i++) begin
      va = int'(a[i*8 +: 8]);
      vb = int'(b[i*8 +: 8]);
      if (sg) begin
        if (va >= 128) va = va - 256;
        if (vb >= 128) vb = vb - 256;
      end
      hit = (f[2] && va < vb) || (f[1] && va == vb) || (f[0] && va > vb);
      e.mask[i] = en[i] && hit;
      if (e.mask[i]) begin
        n = n + 1;
        e.res[i*8] = 1'b1;
      end
    end
    e.any = (e.mask != 4'b0);
    e.all = ((e.mask & en) == en);
    e.cnt = 3'(n);
    return e;
  endfunction

  function automatic vec_t mk(logic [31:0] a, logic [31:0] b, logic [2:0] f, logic sg,
                              logic [3:0] en, logic [3:0] m, logic an, logic al,
                              logic [2:0] c, logic [31:0] r);
    vec_t v;
    v.a = a; v.b = b; v.f = f; v.sg = sg; v.en = en;
    v.exp.mask = m; v.exp.any = an; v.exp.all = al; v.exp.cnt = c; v.exp.res = r;
    return v;
  endfunction

  task automatic chk(string nm, logic [63:0] got, logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, got, want, $time);
    end
  endtask

  task automatic check_out(string nm, exp_t e);
    exp_t got;
    got = {bus.MASK, bus.ANY, bus.ALL, bus.COUNT, bus.RES};
    n_cmp++;
    if (got !== e) begin
      n_err++;
      $display("FAIL %s: got mask=%b any=%b all=%b cnt=%0d res=0x%08h expected mask=%b any=%b all=%b cnt=%0d res=0x%08h",
               nm, got.mask, got.any, got.all, got.cnt, got.res,
               e.mask, e.any, e.all, e.cnt, e.res);
    end
  endtask

  // Scoreboard: everything is sampled on the falling edge, where the handshake is stable.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.IN_VALID && bus.IN_READY)
        sbq.push_back(model(bus.A, bus.B, bus.F, bus.SIGNED, bus.LANE_EN));
      if (bus.OUT_VALID && bus.OUT_READY) begin
        n_pop++;
        if (sbq.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL sb_unexpected: result beat with no outstanding input at %0t", $time);
        end else begin
          check_out("scoreboard", sbq.pop_front());
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the edge that accepted the beat.
  task automatic send(logic [31:0] a, logic [31:0] b, logic [2:0] f, logic sg, logic [3:0] en);
    bus.A = a; bus.B = b; bus.F = f; bus.SIGNED = sg; bus.LANE_EN = en;
    bus.IN_VALID = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (bus.IN_READY) begin
        @(posedge clk);
        #1;
        bus.IN_VALID = 1'b0;
        return;
      end
    end
    chk("send_timeout", 64'd0, 64'd1);
    bus.IN_VALID = 1'b0;
  endtask

  task automatic send_and_check(int idx);
    send(tbl[idx].a, tbl[idx].b, tbl[idx].f, tbl[idx].sg, tbl[idx].en);
    @(negedge clk);
    chk($sformatf("vec%0d_lat1_valid", idx), 64'(bus.OUT_VALID), 64'd0);
    @(negedge clk);
    chk($sformatf("vec%0d_lat2_valid", idx), 64'(bus.OUT_VALID), 64'd1);
    check_out($sformatf("vec%0d", idx), tbl[idx].exp);
    @(posedge clk);
    #1;
  endtask

  task automatic drain(string nm);
    bus.OUT_READY = 1'b1;
    for (int n = 0; n < 50 && sbq.size() != 0; n++) @(posedge clk);
    #1;
    chk(nm, 64'(sbq.size()), 64'd0);
  endtask

  function automatic logic [31:0] rand_b(logic [31:0] a);
    logic [31:0] b;
    b = $urandom;
    for (int i = 0; i < LANES; i++)
      if ($urandom_range(0, 2) == 0) b[i*8 +: 8] = a[i*8 +: 8];
    return b;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   pops0;
    logic done;
    logic [31:0] ra;

    n_cmp = 0; n_err = 0; n_pop = 0;
    tbl[0] = mk(32'h80017F05, 32'h01018006, 3'b100, 1'b1, 4'b1111, 4'b1001, 1, 0, 3'd2, 32'h01000001);
    tbl[1] = mk(32'h80017F05, 32'h01018006, 3'b100, 1'b0, 4'b1111, 4'b0011, 1, 0, 3'd2, 32'h00000101);
    tbl[2] = mk(32'h5A5A5A5A, 32'h5A5A5A5A, 3'b010, 1'b0, 4'b1011, 4'b1011, 1, 1, 3'd3, 32'h01000101);
    tbl[3] = mk(32'h5A5A5A5A, 32'h5A5A5A5A, 3'b101, 1'b0, 4'b1011, 4'b0000, 0, 0, 3'd0, 32'h00000000);
    tbl[4] = mk(32'h80017F05, 32'h01018006, 3'b111, 1'b1, 4'b0000, 4'b0000, 0, 1, 3'd0, 32'h00000000);
    tbl[5] = mk(32'h80017F05, 32'h01018006, 3'b111, 1'b1, 4'b1111, 4'b1111, 1, 1, 3'd4, 32'h01010101);
    tbl[6] = mk(32'h80017F05, 32'h01018006, 3'b000, 1'b1, 4'b1111, 4'b0000, 0, 0, 3'd0, 32'h00000000);
    tbl[7] = mk(32'h80017F05, 32'h01018006, 3'b110, 1'b1, 4'b1111, 4'b1101, 1, 0, 3'd3, 32'h01010001);
    tbl[8] = mk(32'h80017F05, 32'h01018006, 3'b011, 1'b1, 4'b1111, 4'b0110, 1, 0, 3'd2, 32'h00010100);
    tbl[9] = mk(32'h80017F05, 32'h01018006, 3'b000, 1'b0, 4'b0000, 4'b0000, 0, 1, 3'd0, 32'h00000000);

    bus.IN_VALID = 1'b0; bus.A = '0; bus.B = '0; bus.F = '0; bus.SIGNED = 1'b0;
    bus.LANE_EN = '0; bus.OUT_READY = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("reset_outputs", 64'({bus.OUT_VALID, bus.MASK, bus.ANY, bus.ALL, bus.COUNT, bus.RES}), 64'd0);
    chk("reset_in_ready", 64'(bus.IN_READY), 64'd1);
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) send_and_check(i);
    drain("table_drain");

    // Stall: fill both stages, hold the consumer off for three cycles.
    @(posedge clk); #1;
    bus.OUT_READY = 1'b0;
    pops0 = n_pop;
    send(32'h11223344, 32'h11203355, 3'b100, 1'b0, 4'b1111);
    send(32'hF0017FFF, 32'h0F01807F, 3'b001, 1'b1, 4'b1110);
    chk("stall_in_ready_low", 64'(bus.IN_READY), 64'd0);
    bus.IN_VALID = 1'b1;
    for (int c = 0; c < 3; c++) begin
      bus.A = $urandom; bus.B = $urandom; bus.F = 3'($urandom); bus.LANE_EN = 4'($urandom);
      @(negedge clk);
      chk($sformatf("stall%0d_in_ready", c), 64'(bus.IN_READY), 64'd0);
      chk($sformatf("stall%0d_out_valid", c), 64'(bus.OUT_VALID), 64'd1);
      if (sbq.size() != 0) check_out($sformatf("stall%0d_hold", c), sbq[0]);
      @(posedge clk); #1;
    end
    bus.OUT_READY = 1'b1;
    send(32'h00FF8001, 32'h00FF7F02, 3'b101, 1'b1, 4'b0111);
    drain("stall_drain");
    chk("stall_beat_count", 64'(n_pop - pops0), 64'd3);

    // Asynchronous reset mid-cycle with both stages occupied.
    @(posedge clk); #1;
    bus.OUT_READY = 1'b0;
    send(tbl[1].a, tbl[1].b, tbl[1].f, tbl[1].sg, tbl[1].en);
    send(tbl[2].a, tbl[2].b, tbl[2].f, tbl[2].sg, tbl[2].en);
    #3 rst = 1'b1;
    #1;
    chk("midrst_outputs", 64'({bus.OUT_VALID, bus.MASK, bus.ANY, bus.ALL, bus.COUNT, bus.RES}), 64'd0);
    chk("midrst_in_ready", 64'(bus.IN_READY), 64'd1);
    sbq.delete();
    bus.OUT_READY = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("postrst_no_stale", 64'(bus.OUT_VALID), 64'd0);
    @(posedge clk); #1;
    send_and_check(0);
    drain("postrst_drain");

    // Randomized traffic with random backpressure.
    done = 1'b0;
    pops0 = n_pop;
    fork
      begin
        for (int n = 0; n < 300; n++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
          ra = $urandom;
          send(ra, rand_b(ra), 3'($urandom), 1'($urandom), 4'($urandom));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          bus.OUT_READY = ($urandom_range(0, 2) != 0);
          @(posedge clk); #1;
        end
      end
    join
    drain("random_drain");
    chk("random_beat_count", 64'(n_pop - pops0), 64'd300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
